// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_seq_state_t;

  // Width of the shared state counter: enough to hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, releases the core reset, and retries,
// restarts or parks in FAIL depending on lock behaviour and relock requests.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               locked,
  input  logic                               relock_req,
  input  logic                               clr_status,
  output logic                               pll_rst,
  output logic                               core_reset,
  output logic                               ready,
  output logic                               fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
);

  localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  logic           locked_s;
  pll_seq_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]  retries_nxt;
  logic           set_lost;
  logic           lost_nxt;
  logic           restart;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt   = state;
    retries_nxt = retries;
    set_lost    = 1'b0;
    if (relock_req) begin
      state_nxt   = PLL_RST;
      retries_nxt = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retries == RETRY_LIMIT) begin
              state_nxt = FAIL;
            end else begin
              retries_nxt = retries + RW'(1);
              state_nxt   = PLL_RST;
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt   = RUN;
            retries_nxt = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            set_lost  = 1'b1;
            state_nxt = PLL_RST;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = PLL_RST;
        end
      endcase
    end
  end

  // A relock request counts as a fresh entry even when already in PLL_RST.
  assign restart  = relock_req || (state_nxt != state);
  assign cnt_nxt  = restart ? '0 : cnt + CW'(1);
  assign lost_nxt = set_lost | (lock_lost & ~clr_status);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= PLL_RST;
      cnt        <= '0;
      retries    <= '0;
      lock_lost  <= 1'b0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retries    <= retries_nxt;
      lock_lost  <= lost_nxt;
      pll_rst    <= (state_nxt == PLL_RST);
      core_reset <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
      fail       <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: phase/elapsed-time reference model,
// directed timing pins, then randomized lock/relock/clear/reset stimulus.
module tb_pll_reset_sequencer;

  localparam int RP   = 4;
  localparam int TO   = 32;
  localparam int ST   = 8;
  localparam int MAXR = 2;

  localparam int M_PULSE = 0;
  localparam int M_WAIT  = 1;
  localparam int M_QUAL  = 2;
  localparam int M_RUN   = 3;
  localparam int M_FAIL  = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       clr_status = 1'b0;
  logic       pll_rst, core_reset, ready, fail, lock_lost;
  logic [1:0] retries;

  int checks = 0;
  int failures = 0;

  int m_ph = M_PULSE;
  int m_t = 0;
  int m_try = 0;
  bit m_lost = 0;
  bit m_s1 = 0;
  bit m_s2 = 0;
  int edge_n = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .relock_req (relock_req),
    .clr_status (clr_status),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retries    (retries)
  );

  always #5 refclk = ~refclk;

  // Reference: current phase, edges spent in it, retries used, sticky flag, 2-edge lock delay.
  always @(posedge refclk or posedge rst) begin : mdl
    int ph, t, tr;
    bit lost, ls, set_ev;
    if (rst) begin
      m_ph   <= M_PULSE;
      m_t    <= 0;
      m_try  <= 0;
      m_lost <= 0;
      m_s1   <= 0;
      m_s2   <= 0;
      edge_n <= 0;
    end else begin
      ph = m_ph; t = m_t; tr = m_try; lost = m_lost; ls = m_s2; set_ev = 0;
      if (relock_req) begin
        ph = M_PULSE; t = 0; tr = 0;
      end else begin
        case (ph)
          M_PULSE: begin
            t = t + 1;
            if (t == RP) begin ph = M_WAIT; t = 0; end
          end
          M_WAIT: begin
            if (ls) begin
              ph = M_QUAL; t = 0;
            end else begin
              t = t + 1;
              if (t == TO) begin
                if (tr == MAXR) ph = M_FAIL;
                else begin tr = tr + 1; ph = M_PULSE; end
                t = 0;
              end
            end
          end
          M_QUAL: begin
            if (!ls) begin
              ph = M_WAIT; t = 0;
            end else begin
              t = t + 1;
              if (t == ST) begin ph = M_RUN; t = 0; tr = 0; end
            end
          end
          M_RUN: begin
            if (!ls) begin set_ev = 1; ph = M_PULSE; t = 0; end
          end
          default: ;
        endcase
      end
      if (set_ev) lost = 1;
      else if (clr_status) lost = 0;
      m_ph   <= ph;
      m_t    <= t;
      m_try  <= tr;
      m_lost <= lost;
      m_s2   <= m_s1;
      m_s1   <= locked;
      edge_n <= edge_n + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0d expected=%0d", name, edge_n, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("m_pll_rst",    int'(pll_rst),    int'(m_ph == M_PULSE));
    chk("m_core_reset", int'(core_reset), int'(m_ph != M_RUN));
    chk("m_ready",      int'(ready),      int'(m_ph == M_RUN));
    chk("m_fail",       int'(fail),       int'(m_ph == M_FAIL));
    chk("m_lock_lost",  int'(lock_lost),  int'(m_lost));
    chk("m_retries",    int'(retries),    m_try);
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
    compare_model();
  endtask

  task automatic tick_to(input int n);
    int guard;
    guard = 0;
    while (edge_n < n && guard < 2000) begin
      tick();
      guard++;
    end
    if (edge_n < n) chk("tick_to_timeout", edge_n, n);
  endtask

  task automatic do_reset();
    @(negedge refclk);
    relock_req = 0;
    clr_status = 0;
    rst = 1;
    #1;
    chk("rst_pll_rst",    int'(pll_rst),    1);
    chk("rst_core_reset", int'(core_reset), 1);
    chk("rst_ready",      int'(ready),      0);
    chk("rst_fail",       int'(fail),       0);
    chk("rst_lock_lost",  int'(lock_lost),  0);
    chk("rst_retries",    int'(retries),    0);
    compare_model();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    // Nominal lock, then loss of lock in RUN and status clear
    locked = 0;
    do_reset();
    tick_to(3);  chk("nom_pulse_hi", int'(pll_rst), 1);
    tick_to(4);  chk("nom_pulse_lo", int'(pll_rst), 0);
    tick_to(9);  locked = 1;
    tick_to(19); chk("nom_ready_early", int'(ready), 0);
    tick_to(20); chk("nom_ready", int'(ready), 1);
    chk("nom_core_reset", int'(core_reset), 0);
    chk("nom_retries", int'(retries), 0);
    tick_to(25); locked = 0;
    tick_to(27); chk("loss_core_still_low", int'(core_reset), 0);
    tick_to(28); chk("loss_core_reset", int'(core_reset), 1);
    chk("loss_lock_lost", int'(lock_lost), 1);
    chk("loss_pulse_hi", int'(pll_rst), 1);
    tick_to(31); chk("loss_pulse_end", int'(pll_rst), 1);
    tick_to(32); chk("loss_pulse_lo", int'(pll_rst), 0);
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("clr_lock_lost", int'(lock_lost), 0);

    // Glitch during qualification restarts the full stable window
    locked = 0;
    do_reset();
    tick_to(9);  locked = 1;
    tick_to(17); locked = 0;
    tick_to(19); locked = 1;
    tick_to(20); chk("glitch_no_ready", int'(ready), 0);
    tick_to(29); chk("glitch_ready_early", int'(ready), 0);
    chk("glitch_retries", int'(retries), 0);
    tick_to(30); chk("glitch_ready", int'(ready), 1);

    // Mid-sequence reset in STABLE
    locked = 0;
    do_reset();
    tick_to(9);  locked = 1;
    tick_to(14);
    do_reset();
    tick_to(3);  chk("mid_pulse_hi", int'(pll_rst), 1);
    tick_to(4);  chk("mid_pulse_lo", int'(pll_rst), 0);
    tick_to(12); chk("mid_ready_early", int'(ready), 0);
    tick_to(13); chk("mid_ready", int'(ready), 1);

    // Relock request coinciding with the FSM seeing a lock drop in RUN
    tick_to(22); locked = 0;
    tick_to(24); relock_req = 1;
    tick();
    relock_req = 0;
    chk("prio_lock_lost", int'(lock_lost), 0);
    chk("prio_pll_rst", int'(pll_rst), 1);

    // No lock ever: three attempts then FAIL, then relock from FAIL
    locked = 0;
    do_reset();
    tick_to(35);  chk("nolock_gap", int'(pll_rst), 0);
    tick_to(36);  chk("nolock_pulse2", int'(pll_rst), 1);
    chk("nolock_retry1", int'(retries), 1);
    tick_to(72);  chk("nolock_pulse3", int'(pll_rst), 1);
    chk("nolock_retry2", int'(retries), 2);
    tick_to(107); chk("nolock_fail_early", int'(fail), 0);
    tick_to(108); chk("nolock_fail", int'(fail), 1);
    chk("nolock_fail_retries", int'(retries), 2);
    chk("nolock_fail_pll_rst", int'(pll_rst), 0);
    tick_to(110); relock_req = 1;
    tick();
    relock_req = 0;
    chk("relock_fail_clr", int'(fail), 0);
    chk("relock_retries", int'(retries), 0);
    chk("relock_pulse_hi", int'(pll_rst), 1);
    tick_to(114); chk("relock_pulse_end", int'(pll_rst), 1);
    tick_to(115); chk("relock_pulse_lo", int'(pll_rst), 0);

    // Randomized lock behaviour, relock requests, status clears and resets
    locked = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      relock_req = ($urandom_range(0, 299) == 0);
      clr_status = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
